mem_req_buffer: RTL
===================

MEM_REQ_BUFFER -- requirements
Module: mem_req_buffer

Interface
REQ-001 Parameter REQ_DEPTH, default 4, SHALL set the request-queue entry count (power of two, at least 2).
REQ-002 Parameter DATA_DEPTH, default 8, SHALL set the write-data-queue entry count (power of two, at least 2).
REQ-003 Parameter MAX_RD, default 4, SHALL set the maximum number of outstanding reads (1..15).
REQ-004 clk  in  1  sole clock; all state SHALL update on the rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 up_req_valid/up_req_ready  in/out  1/1  upstream request handshake, from the arbiter.
REQ-007 up_req_rw, up_req_addr, up_req_tag  in  1/`MEM_ADDR_BITS/`MEM_TAG_BITS  request fields; rw=1 means write.
REQ-008 up_data_valid/up_data_ready  in/out  1/1  upstream write-data handshake.
REQ-009 up_data_bits, up_data_mask, up_data_offset  in  `MEM_DATA_BITS/`MEM_DATA_BITS/8/2  write-data beat.
REQ-010 dn_req_valid/dn_req_ready  out/in  1/1, plus dn_req_rw/addr/tag (out, same widths)  main-memory request channel.
REQ-011 dn_data_valid/dn_data_ready  out/in  1/1, plus dn_data_bits/mask/offset (out)  main-memory write-data channel.
REQ-012 dn_resp_valid, dn_resp_data, dn_resp_tag  in  1/`MEM_DATA_BITS/`MEM_TAG_BITS  main-memory response.
REQ-013 up_resp_valid, up_resp_data, up_resp_tag  out  same widths  response returned to the arbiter and caches.
REQ-014 rd_outstanding  out  4  live count of outstanding reads.
REQ-015 resp_err  out  1  sticky flag: response received with no read outstanding.

Function
REQ-016 The request queue SHALL be FIFO; an upstream handshake (valid&&ready) SHALL push {rw,addr,tag}.
REQ-017 up_req_ready SHALL be high exactly when the request queue is not full; there is no same-cycle pop bypass, so ready is low when full even if a pop occurs that cycle.
REQ-018 A pushed entry SHALL become visible on dn_req_* no earlier than the next cycle (one-cycle minimum latency).
REQ-019 While the queue is non-empty and not read-gated, dn_req_valid SHALL be high and dn_req_* SHALL show the head entry, held stable until dn_req_ready.
REQ-020 Read gating: when the head entry is a read and rd_outstanding==MAX_RD, dn_req_valid SHALL be low; writes at the head are never gated.
REQ-021 Gating SHALL use the registered count; a response arriving in the same cycle unblocks the head only from the next cycle.
REQ-022 rd_outstanding SHALL change as follows: +1 on a downstream read handshake; -1 on dn_resp_valid; unchanged when both occur in the same cycle.
REQ-023 On dn_resp_valid with rd_outstanding==0 (and no same-cycle read handshake), the count SHALL stay 0 and resp_err SHALL set until reset.
REQ-024 The write-data queue SHALL be an independent FIFO with the same ready/visibility rules as REQ-017/REQ-018; beats SHALL be forwarded in order, unrelated to request-queue position.
REQ-025 up_resp_* SHALL equal dn_resp_* delayed exactly one cycle; responses have no backpressure; up_resp_data/tag SHALL hold their last value while up_resp_valid is low.
REQ-026 Queue pointers SHALL wrap modulo depth; full/empty SHALL be derived from an extra wrap bit, giving no aliasing at full.

Reset
REQ-027 Asserting reset (low) SHALL immediately empty both queues and clear rd_outstanding and resp_err.
REQ-028 During reset, all valid outputs SHALL be 0, all ready outputs SHALL be 0, and all data/tag/address outputs SHALL be 0.
REQ-029 After release, both ready outputs SHALL be 1 from the first clock edge, and no stale entry SHALL be emitted.
REQ-030 A response arriving after a mid-operation reset SHALL be forwarded and SHALL set resp_err (REQ-023).

Structure
REQ-031 `MEM_ADDR_BITS, `MEM_TAG_BITS and `MEM_DATA_BITS SHALL come from the shared memory-interface defines header; no local redefinition.
REQ-032 One generic sub-module, mem_fifo (parameters WIDTH and DEPTH), SHALL be instantiated twice: once for requests and once for write data.
REQ-033 The outstanding counter, gating logic and response register SHALL reside in mem_req_buffer.

Verification
REQ-034 Push 4 reads (addr 0x10..0x13, tags 0..3) with dn_req_ready=1 -> dn_req emerges in order, starting 1 cycle after the first push; rd_outstanding reaches 4.
REQ-035 With rd_outstanding=4, push read addr 0x20 -> dn_req_valid stays 0; dn_resp_valid pulses once -> the next cycle count=3, dn_req_valid=1, and after the handshake count=4.
REQ-036 With dn_req_ready=0, push 4 writes -> up_req_ready falls on the cycle after the 4th push; then dn_req_ready=1 -> entries drain in order and ready returns.
REQ-037 Same cycle: read handshake downstream plus dn_resp_valid, at count=2 -> count remains 2.
REQ-038 dn_resp_valid with tag 5, data 0xA5.., at count 0 -> up_resp shows tag 5 one cycle later, resp_err=1 and sticky.
REQ-039 Assert reset while both queues hold 3 entries -> all valid outputs drop to 0 asynchronously; after release, both readies are 1 and nothing is emitted.

Source files
------------

// File: rtl/mem_req_buffer_pkg.sv
// Types and helpers shared by mem_req_buffer and its FIFOs.
`include "mem_if_defines.sv"

package mem_req_buffer_pkg;

  localparam int ADDR_W   = `MEM_ADDR_BITS;
  localparam int TAG_W    = `MEM_TAG_BITS;
  localparam int DATA_W   = `MEM_DATA_BITS;
  localparam int MASK_W   = `MEM_DATA_BITS / 8;
  localparam int OFFSET_W = 2;
  localparam int CNT_W    = 4;

  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [TAG_W-1:0]  tag;
  } mem_req_t;

  typedef struct packed {
    logic [DATA_W-1:0]   bits;
    logic [MASK_W-1:0]   mask;
    logic [OFFSET_W-1:0] offset;
  } mem_beat_t;

  localparam int REQ_W  = $bits(mem_req_t);
  localparam int BEAT_W = $bits(mem_beat_t);

  // A read issued and a response returned in the same cycle cancel out;
  // a response with nothing outstanding leaves the count at zero.
  function automatic logic [CNT_W-1:0] next_outstanding(
    input logic [CNT_W-1:0] cnt,
    input logic             rd_fire,
    input logic             resp_fire
  );
    logic [CNT_W-1:0] nxt;
    nxt = cnt;
    if (rd_fire && !resp_fire) begin
      nxt = cnt + 1'b1;
    end else if (resp_fire && !rd_fire && (cnt != '0)) begin
      nxt = cnt - 1'b1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/mem_fifo.sv
// Generic FIFO with wrap-bit pointers; push_ready is withheld during reset and
// pop_data reads as zero whenever the FIFO is empty.
module mem_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [WIDTH-1:0] push_data,
  output logic             pop_valid,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] pop_data
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             full;
  logic             empty;
  logic             push_fire;
  logic             pop_fire;

  // Same index with differing wrap bits means the writer has lapped the reader.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);

  // Ready depends only on registered fullness: a pop this cycle never frees a slot early.
  assign push_ready = rst_n && !full;
  assign pop_valid  = !empty;
  assign push_fire  = push_valid && push_ready;
  assign pop_fire   = pop_ready && !empty;
  assign pop_data   = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_fire) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_fire) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_fire) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/mem_if_defines.sv
// Shared memory-interface widths used by every block that talks to main memory.
`ifndef MEM_IF_DEFINES_SV
`define MEM_IF_DEFINES_SV
`define MEM_ADDR_BITS 32
`define MEM_TAG_BITS 8
`define MEM_DATA_BITS 64
`endif

// File: rtl/mem_req_buffer.sv
// Buffers arbiter requests and write data toward main memory, limits the number
// of reads in flight, and returns memory responses one cycle later.
`include "mem_if_defines.sv"

module mem_req_buffer
  import mem_req_buffer_pkg::*;
#(
  parameter int REQ_DEPTH  = 4,
  parameter int DATA_DEPTH = 8,
  parameter int MAX_RD     = 4
) (
  input  logic                       clk,
  input  logic                       reset,

  input  logic                       up_req_valid,
  output logic                       up_req_ready,
  input  logic                       up_req_rw,
  input  logic [`MEM_ADDR_BITS-1:0]  up_req_addr,
  input  logic [`MEM_TAG_BITS-1:0]   up_req_tag,

  input  logic                       up_data_valid,
  output logic                       up_data_ready,
  input  logic [`MEM_DATA_BITS-1:0]  up_data_bits,
  input  logic [`MEM_DATA_BITS/8-1:0] up_data_mask,
  input  logic [1:0]                 up_data_offset,

  output logic                       dn_req_valid,
  input  logic                       dn_req_ready,
  output logic                       dn_req_rw,
  output logic [`MEM_ADDR_BITS-1:0]  dn_req_addr,
  output logic [`MEM_TAG_BITS-1:0]   dn_req_tag,

  output logic                       dn_data_valid,
  input  logic                       dn_data_ready,
  output logic [`MEM_DATA_BITS-1:0]  dn_data_bits,
  output logic [`MEM_DATA_BITS/8-1:0] dn_data_mask,
  output logic [1:0]                 dn_data_offset,

  input  logic                       dn_resp_valid,
  input  logic [`MEM_DATA_BITS-1:0]  dn_resp_data,
  input  logic [`MEM_TAG_BITS-1:0]   dn_resp_tag,

  output logic                       up_resp_valid,
  output logic [`MEM_DATA_BITS-1:0]  up_resp_data,
  output logic [`MEM_TAG_BITS-1:0]   up_resp_tag,

  output logic [3:0]                 rd_outstanding,
  output logic                       resp_err
);

  // Every channel: a transfer happens on a cycle where valid && ready at the
  // rising edge; once raised, valid and its payload stay put until that transfer.

  localparam logic [CNT_W-1:0] MAX_RD_CNT = CNT_W'(MAX_RD);

  mem_req_t  req_in;
  mem_req_t  req_head;
  logic      req_head_valid;
  logic      req_pop;
  logic      rd_gate;
  logic      rd_fire;

  mem_beat_t beat_in;
  mem_beat_t beat_head;

  assign req_in  = '{rw: up_req_rw, addr: up_req_addr, tag: up_req_tag};
  assign beat_in = '{bits: up_data_bits, mask: up_data_mask, offset: up_data_offset};

  mem_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (REQ_DEPTH)
  ) u_req_fifo (
    .clk        (clk),
    .rst_n      (reset),
    .push_valid (up_req_valid),
    .push_ready (up_req_ready),
    .push_data  (req_in),
    .pop_valid  (req_head_valid),
    .pop_ready  (req_pop),
    .pop_data   (req_head)
  );

  mem_fifo #(
    .WIDTH (BEAT_W),
    .DEPTH (DATA_DEPTH)
  ) u_data_fifo (
    .clk        (clk),
    .rst_n      (reset),
    .push_valid (up_data_valid),
    .push_ready (up_data_ready),
    .push_data  (beat_in),
    .pop_valid  (dn_data_valid),
    .pop_ready  (dn_data_ready),
    .pop_data   (beat_head)
  );

  // A read at the head waits while the registered in-flight count is at its limit;
  // a response landing this cycle only releases it on the following cycle.
  assign rd_gate      = req_head_valid && !req_head.rw && (rd_outstanding == MAX_RD_CNT);
  assign dn_req_valid = req_head_valid && !rd_gate;
  assign req_pop      = dn_req_valid && dn_req_ready;
  assign rd_fire      = req_pop && !req_head.rw;

  assign dn_req_rw   = req_head.rw;
  assign dn_req_addr = req_head.addr;
  assign dn_req_tag  = req_head.tag;

  assign dn_data_bits   = beat_head.bits;
  assign dn_data_mask   = beat_head.mask;
  assign dn_data_offset = beat_head.offset;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_outstanding <= '0;
      resp_err       <= 1'b0;
    end else begin
      rd_outstanding <= next_outstanding(rd_outstanding, rd_fire, dn_resp_valid);
      if (dn_resp_valid && !rd_fire && (rd_outstanding == '0)) begin
        resp_err <= 1'b1;
      end
    end
  end

  // Responses cannot be stalled; the payload is captured only on a valid beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      up_resp_valid <= 1'b0;
      up_resp_data  <= '0;
      up_resp_tag   <= '0;
    end else begin
      up_resp_valid <= dn_resp_valid;
      if (dn_resp_valid) begin
        up_resp_data <= dn_resp_data;
        up_resp_tag  <= dn_resp_tag;
      end
    end
  end

endmodule
